// File: rtl/mac_chain_pkg.sv
// ---------------------------------------------------------------------------
// mac_chain_pkg
// Shared constants and types for the multiply-add chain operand loader.
//   DATA_WIDTH   : width of a, b, c and of each chain stage
//   NUM_STAGES   : beats per frame, one per chain stage
//   CNT_W        : width of the beat counter (2**CNT_W > NUM_STAGES)
//   state_t      : loader state, FILL while collecting beats, HOLD while
//                  presenting a completed frame
//   slice_offset : bit offset of stage k inside a packed stage vector
// ---------------------------------------------------------------------------
package mac_chain_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int NUM_STAGES = 10;
   localparam int CNT_W      = 4;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   // The width argument defaults to the chain width but lets a loader built
   // with an overridden width reuse the same slicing rule.
   function automatic int slice_offset(input int k, input int width = DATA_WIDTH);
      return width * k;
   endfunction

endpackage

// File: rtl/mac_chain_loader.sv
// ---------------------------------------------------------------------------
// mac_chain_loader
// Stages one (b, c) pair per beat from a valid/ready stream into the packed
// parallel vectors consumed by the multiply-add chain, capturing the seed
// operand a on beat 0. After NUM_STAGES beats the frame is held stable under
// a valid/ready handshake until the chain side accepts it.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   s_valid   in   input beat valid
//   s_ready   out  loader can accept a beat (forced low while rst_n is low)
//   s_a       in   seed operand, sampled on beat 0 only
//   s_b       in   b coefficient for the current stage
//   s_c       in   c addend for the current stage
//   clear     in   discard a partial frame (ignored while holding a frame)
//   m_valid   out  packed frame valid
//   m_ready   in   chain side accepts the frame
//   m_a       out  seed operand to stage 1
//   m_b       out  packed b, stage k at [DATA_WIDTH*k +: DATA_WIDTH]
//   m_c       out  packed c, same slicing as m_b
//   beat_cnt  out  beats captured in the current frame
// ---------------------------------------------------------------------------
module mac_chain_loader #(
   parameter int DATA_WIDTH = mac_chain_pkg::DATA_WIDTH,
   parameter int NUM_STAGES = mac_chain_pkg::NUM_STAGES,
   parameter int CNT_W      = mac_chain_pkg::CNT_W
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [DATA_WIDTH-1:0]           s_a,
   input  logic [DATA_WIDTH-1:0]           s_b,
   input  logic [DATA_WIDTH-1:0]           s_c,
   input  logic                            clear,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [DATA_WIDTH-1:0]           m_a,
   output logic [DATA_WIDTH*NUM_STAGES-1:0] m_b,
   output logic [DATA_WIDTH*NUM_STAGES-1:0] m_c,
   output logic [CNT_W-1:0]                beat_cnt
);

   import mac_chain_pkg::*;

   // One-hot write enable for the slice addressed by the beat counter.
   function automatic logic [NUM_STAGES-1:0] slice_decode(input logic [CNT_W-1:0] cnt);
      logic [NUM_STAGES-1:0] en;
      en = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         en[k] = (cnt == CNT_W'(k));
      end
      return en;
   endfunction

   state_t                state;
   logic [NUM_STAGES-1:0] slice_en;
   logic                  last_beat;

   assign slice_en  = slice_decode(beat_cnt);
   assign last_beat = (beat_cnt == CNT_W'(NUM_STAGES - 1));

   // s_ready is gated by rst_n so no beat is offered acceptance while the
   // loader is being reset, even though the state register still reads FILL.
   assign s_ready = rst_n && (state == FILL);
   assign m_valid = (state == HOLD);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= FILL;
         beat_cnt <= '0;
         m_a      <= '0;
         m_b      <= '0;
         m_c      <= '0;
      end else begin
         case (state)
            FILL: begin
               // clear wins over a same-cycle beat; old slice contents are
               // left in place because the next frame overwrites them.
               if (clear) begin
                  beat_cnt <= '0;
               end else if (s_valid) begin
                  for (int k = 0; k < NUM_STAGES; k++) begin
                     if (slice_en[k]) begin
                        m_b[slice_offset(k, DATA_WIDTH) +: DATA_WIDTH] <= s_b;
                        m_c[slice_offset(k, DATA_WIDTH) +: DATA_WIDTH] <= s_c;
                     end
                  end
                  if (beat_cnt == '0) begin
                     m_a <= s_a;
                  end
                  if (last_beat) begin
                     beat_cnt <= '0;
                     state    <= HOLD;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (m_ready) begin
                  state <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_mac_chain_loader
// Bench for mac_chain_loader. A frame-level model (queue of accepted beats,
// a held-frame copy and a holding flag) predicts s_ready, m_valid, beat_cnt
// and the held frame contents; a negedge process compares every cycle.
// Directed phases add literal expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_mac_chain_loader;

   localparam int DW = 16;
   localparam int NS = 10;
   localparam int CW = 4;

   logic            clk;
   logic            rst_n;
   logic            s_valid;
   logic            s_ready;
   logic [DW-1:0]   s_a;
   logic [DW-1:0]   s_b;
   logic [DW-1:0]   s_c;
   logic            clear;
   logic            m_valid;
   logic            m_ready;
   logic [DW-1:0]   m_a;
   logic [DW*NS-1:0] m_b;
   logic [DW*NS-1:0] m_c;
   logic [CW-1:0]   beat_cnt;

   mac_chain_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_a      (s_a),
      .s_b      (s_b),
      .s_c      (s_c),
      .clear    (clear),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_a      (m_a),
      .m_b      (m_b),
      .m_c      (m_c),
      .beat_cnt (beat_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [DW*NS-1:0] act,
                        input logic [DW*NS-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit            hold_m = 1'b0;  // a completed frame is being offered
   bit            took   = 1'b0;  // the last edge accepted a beat
   bit            chk_en = 1'b0;
   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];
   logic [DW-1:0] qc[$];
   logic [DW-1:0] fa;
   logic [DW-1:0] fb[NS];
   logic [DW-1:0] fc[NS];

   always @(posedge clk) begin
      took = 1'b0;
      if (!rst_n) begin
         hold_m = 1'b0;
         qa.delete(); qb.delete(); qc.delete();
      end else if (!hold_m) begin
         if (clear) begin
            qa.delete(); qb.delete(); qc.delete();
         end else if (s_valid) begin
            took = 1'b1;
            qa.push_back(s_a); qb.push_back(s_b); qc.push_back(s_c);
            if (qb.size() == NS) begin
               fa = qa[0];
               for (int k = 0; k < NS; k++) begin
                  fb[k] = qb[k];
                  fc[k] = qc[k];
               end
               qa.delete(); qb.delete(); qc.delete();
               hold_m = 1'b1;
            end
         end
      end else if (m_ready) begin
         hold_m = 1'b0;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [DW*NS-1:0] eb;
      logic [DW*NS-1:0] ec;
      if (chk_en) begin
         check("s_ready", s_ready, rst_n && !hold_m);
         check("m_valid", m_valid, hold_m);
         check("beat_cnt", beat_cnt, qb.size());
         if (hold_m) begin
            for (int k = 0; k < NS; k++) begin
               eb[k*DW +: DW] = fb[k];
               ec[k*DW +: DW] = fc[k];
            end
            check("m_a", m_a, fa);
            check("m_b", m_b, eb);
            check("m_c", m_c, ec);
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // New beat data only after the previous one was accepted (source holds).
   task automatic drive_data();
      if (took) begin
         s_a = DW'($urandom);
         s_b = DW'($urandom);
         s_c = DW'($urandom);
      end
   endtask

   task automatic rand_beats(input int n);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_a = DW'($urandom);
         s_b = DW'($urandom);
         s_c = DW'($urandom);
         tick();
      end
   endtask

   logic [DW*NS-1:0] snap_b;
   logic [DW-1:0]    snap_a;
   int               nvalid;

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; clear = 1'b0; m_ready = 1'b1;
      s_a = '0; s_b = '0; s_c = '0;

      // reset state
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_m_valid", m_valid, 0);
      check("rst_beat_cnt", beat_cnt, 0);
      check("rst_m_b", m_b, 0);
      check("rst_s_ready", s_ready, 0);
      rst_n = 1'b1;
      #1;
      check("rel_s_ready", s_ready, 1);

      // directed frame with hand-computed expectations
      for (int k = 0; k < NS; k++) begin
         s_valid = 1'b1;
         s_a = (k == 0) ? 16'h0003 : DW'($urandom);
         s_b = DW'(k + 1);
         s_c = DW'(16'h0100 + k);
         tick();
      end
      s_valid = 1'b0;
      check("lit_m_valid", m_valid, 1);
      check("lit_m_a", m_a, 16'h0003);
      check("lit_b0", m_b[15:0], 16'h0001);
      check("lit_b9", m_b[159:144], 16'h000A);
      check("lit_c9", m_c[159:144], 16'h0109);
      tick();
      check("lit_s_ready_after", s_ready, 1);

      // backpressure: frame held for 5 cycles with s_valid high
      m_ready = 1'b0;
      rand_beats(NS);
      snap_b = m_b;
      snap_a = m_a;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_s_ready", s_ready, 0);
         check("bp_m_b_stable", m_b, snap_b);
         check("bp_m_a_stable", m_a, snap_a);
      end
      m_ready = 1'b1;
      tick();
      check("bp_xfer_m_valid", m_valid, 0);
      s_a = DW'($urandom); s_b = DW'($urandom); s_c = DW'($urandom);
      tick();
      check("bp_next_beat", beat_cnt, 1);

      // clear with a same-cycle beat
      s_valid = 1'b0; clear = 1'b1;
      tick();
      clear = 1'b0;
      rand_beats(4);
      clear = 1'b1; s_valid = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_beat_cnt", beat_cnt, 0);
      for (int k = 0; k < NS; k++) begin
         s_valid = 1'b1;
         s_a = (k == 0) ? 16'hBEEF : DW'($urandom);
         s_b = DW'($urandom);
         s_c = DW'($urandom);
         tick();
      end
      s_valid = 1'b0;
      check("clr_m_valid", m_valid, 1);
      check("clr_m_a", m_a, 16'hBEEF);
      tick();

      // reset in the middle of a frame
      rand_beats(7);
      s_valid = 1'b0; rst_n = 1'b0;
      tick();
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_beat_cnt", beat_cnt, 0);
      check("mid_rst_m_b", m_b, 0);
      check("mid_rst_m_c", m_c, 0);
      rst_n = 1'b1;
      rand_beats(NS);
      s_valid = 1'b0;
      tick();

      // back-to-back frames: 3 frames in 33 cycles
      m_ready = 1'b1; s_valid = 1'b1;
      s_a = DW'($urandom); s_b = DW'($urandom); s_c = DW'($urandom);
      nvalid = 0;
      for (int i = 0; i < 33; i++) begin
         drive_data();
         tick();
         if (m_valid) nvalid++;
      end
      check("b2b_frames", nvalid, 3);
      check("b2b_end_cnt", beat_cnt, 0);

      // s_valid toggling every cycle
      for (int i = 0; i < 44; i++) begin
         s_valid = (i % 2 == 0);
         drive_data();
         tick();
      end

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n   = ($urandom_range(0, 99) != 0);
         s_valid = ($urandom_range(0, 9) < 7);
         m_ready = ($urandom_range(0, 9) < 6);
         clear   = ($urandom_range(0, 99) < 4);
         drive_data();
         tick();
      end
      rst_n = 1'b1; clear = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
